// File: rtl/tile_ram_arbiter_if.sv
// Bus bundle between the graphics reader, the game-logic writer and the tile RAM.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface tile_ram_arbiter_if #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              video_on;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              overflow;
    logic [CNT_W-1:0]  pending;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output video_on, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
        input  rd_data, rd_valid, wr_ready, overflow, pending, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  video_on, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
        output rd_data, rd_valid, wr_ready, overflow, pending, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/tile_ram_arbiter.sv
// Single-port tile RAM arbiter: pixel reads always win, game-logic writes are
// buffered in a small FIFO and drained in read-free (optionally blanking-only) cycles.
module tile_ram_arbiter #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          TEAR_FREE  = 1'b1
) (
    input  logic              clock_25,
    input  logic              reset_key,
    tile_ram_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q;
    logic [1:0]        rd_pipe_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              full, push, pop, drain_ok;

    assign full     = (count_q == FULL_CNT);
    assign push     = bus.wr_req && !full;
    assign drain_ok = !TEAR_FREE || !bus.video_on;
    assign pop      = (state_d == WR);

    always_comb begin
        state_d = IDLE;
        if (bus.rd_req) begin
            state_d = RD;
        end else if ((count_q != '0) && drain_ok) begin
            state_d = WR;
        end
    end

    // RAM address/data are registered alongside the decision; ram_we is decoded from the state.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        unique case (state_d)
            RD: ram_addr_d = bus.rd_addr;
            WR: begin
                ram_addr_d  = fifo_addr_q[rd_ptr_q];
                ram_wdata_d = fifo_data_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            count_q     <= count_d;
            rd_pipe_q   <= {rd_pipe_q[0], bus.rd_req};
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (bus.wr_req && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock_25) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
            fifo_data_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data   = bus.ram_rdata;
    assign bus.rd_valid  = rd_pipe_q[1];
    assign bus.wr_ready  = !full;
    assign bus.overflow  = overflow_q;
    assign bus.pending   = count_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = (state_q == WR);
    assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tile_ram_arbiter;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tile_ram_arbiter_if #(.ADDR_W(9), .DATA_W(3), .FIFO_DEPTH(DEPTH)) bus ();
    tile_ram_arbiter_if #(.ADDR_W(9), .DATA_W(3), .FIFO_DEPTH(DEPTH)) bus_nt ();

    tile_ram_arbiter #(.ADDR_W(9), .DATA_W(3), .FIFO_DEPTH(DEPTH), .TEAR_FREE(1'b1)) u_dut (
        .clock_25 (clk),
        .reset_key(rst_n),
        .bus      (bus)
    );

    // Second instance without tear-free gating, fed the same stimulus.
    tile_ram_arbiter #(.ADDR_W(9), .DATA_W(3), .FIFO_DEPTH(DEPTH), .TEAR_FREE(1'b0)) u_dut_nt (
        .clock_25 (clk),
        .reset_key(rst_n),
        .bus      (bus_nt)
    );

    assign bus_nt.video_on  = bus.video_on;
    assign bus_nt.rd_req    = bus.rd_req;
    assign bus_nt.rd_addr   = bus.rd_addr;
    assign bus_nt.wr_req    = bus.wr_req;
    assign bus_nt.wr_addr   = bus.wr_addr;
    assign bus_nt.wr_data   = bus.wr_data;
    assign bus_nt.ram_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tile RAM with one-cycle read latency.
    logic [2:0]  ram [512];
    int          we_count = 0;
    int unsigned wlog[$];

    initial begin
        forever begin
            @(posedge clk);
            bus.ram_rdata <= ram[bus.ram_addr];
            if (bus.ram_we) begin
                ram[bus.ram_addr] <= bus.ram_wdata;
                we_count++;
                wlog.push_back(int'(bus.ram_addr));
            end
        end
    end

    // Reference model: queue of accepted writes and a shadow of the RAM contents.
    logic [2:0]  model_mem [512];
    int unsigned q_addr[$];
    int unsigned q_data[$];
    logic        m_we    = 1'b0;
    logic [8:0]  m_addr  = '0;
    logic [2:0]  m_wdata = '0;
    logic [2:0]  m_rdata = '0;
    logic        m_ovf   = 1'b0;
    logic        m_v1    = 1'b0;
    logic        m_v2    = 1'b0;

    task automatic model_step();
        bit was_full;
        if (!rst_n) begin
            q_addr.delete();
            q_data.delete();
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_ovf = 1'b0; m_v1 = 1'b0; m_v2 = 1'b0;
        end else begin
            m_rdata = model_mem[m_addr];
            if (m_we) model_mem[m_addr] = m_wdata;
            was_full = (q_addr.size() == DEPTH);
            m_v2 = m_v1;
            m_v1 = bus.rd_req;
            if (bus.rd_req) begin
                m_we   = 1'b0;
                m_addr = bus.rd_addr;
            end else if (q_addr.size() > 0 && !bus.video_on) begin
                m_we    = 1'b1;
                m_addr  = 9'(q_addr.pop_front());
                m_wdata = 3'(q_data.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (bus.wr_req) begin
                if (was_full) m_ovf = 1'b1;
                else begin
                    q_addr.push_back(int'(bus.wr_addr));
                    q_data.push_back(int'(bus.wr_data));
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("ram_we", int'(bus.ram_we), int'(m_we));
            check("ram_addr", int'(bus.ram_addr), int'(m_addr));
            if (m_we) check("ram_wdata", int'(bus.ram_wdata), int'(m_wdata));
            check("pending", int'(bus.pending), q_addr.size());
            check("wr_ready", int'(bus.wr_ready), int'(q_addr.size() < DEPTH));
            check("overflow", int'(bus.overflow), int'(m_ovf));
            check("rd_valid", int'(bus.rd_valid), int'(m_v2));
            if (m_v2) check("rd_data", int'(bus.rd_data), int'(m_rdata));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 512; i++) begin
            ram[i]       = 3'(i % 8);
            model_mem[i] = 3'(i % 8);
        end
        ram[5]       = 3'd3;
        model_mem[5] = 3'd3;
        bus.video_on = 1'b1;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_req   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_wr_ready", int'(bus.wr_ready), 1);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_ram_we", int'(bus.ram_we), 0);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_ram_addr", int'(bus.ram_addr), 0);

        // Read pipeline: address 5 holds 3.
        bus.rd_req = 1'b1; bus.rd_addr = 9'd5;
        cyc(1);
        check("rd_addr_n1", int'(bus.ram_addr), 5);
        check("rd_valid_n1", int'(bus.rd_valid), 0);
        bus.rd_req = 1'b0;
        cyc(1);
        check("rd_valid_n2", int'(bus.rd_valid), 1);
        check("rd_data_n2", int'(bus.rd_data), 3);
        cyc(1);
        check("rd_valid_n3", int'(bus.rd_valid), 0);

        // Tear-free hold with video_on high.
        base = we_count;
        bus.wr_req = 1'b1; bus.wr_addr = 9'h10; bus.wr_data = 3'd2;
        cyc(1);
        bus.wr_req = 1'b0;
        check("tf_pending", int'(bus.pending), 1);
        check("nt_pending", int'(bus_nt.pending), 1);
        check("nt_ram_we_early", int'(bus_nt.ram_we), 0);
        cyc(1);
        check("nt_ram_we", int'(bus_nt.ram_we), 1);
        check("nt_ram_addr", int'(bus_nt.ram_addr), 16);
        for (int i = 0; i < 3; i++) begin
            check("tf_hold_we", int'(bus.ram_we), 0);
            cyc(1);
        end
        check("tf_hold_pending", int'(bus.pending), 1);
        bus.video_on = 1'b0;
        cyc(1);
        check("tf_we", int'(bus.ram_we), 1);
        check("tf_addr", int'(bus.ram_addr), 16);
        check("tf_wdata", int'(bus.ram_wdata), 2);
        check("tf_pending0", int'(bus.pending), 0);
        cyc(1);
        check("tf_we_off", int'(bus.ram_we), 0);
        check("tf_pulses", we_count - base, 1);
        check("tf_ram16", int'(ram[16]), 2);

        // Fill and overflow during active video.
        bus.video_on = 1'b1;
        wlog.delete();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) check("full_wr_ready", int'(bus.wr_ready), 0);
            bus.wr_req = 1'b1; bus.wr_addr = 9'(i); bus.wr_data = 3'(i);
            cyc(1);
        end
        bus.wr_req = 1'b0;
        check("full_pending", int'(bus.pending), 4);
        check("full_wr_ready2", int'(bus.wr_ready), 0);
        check("full_overflow", int'(bus.overflow), 1);
        bus.video_on = 1'b0;
        cyc(6);
        check("drain_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) check("drain_order", int'(wlog[i]), i + 1);
        end
        check("drain_wr_ready", int'(bus.wr_ready), 1);
        check("drain_overflow", int'(bus.overflow), 1);
        check("drain_ram4", int'(ram[4]), 4);
        check("dropped_ram5", int'(ram[5]), 3);

        // Read priority with alternating rd_req in blanking.
        base = we_count;
        bus.rd_req = 1'b1; bus.rd_addr = 9'd1; bus.wr_req = 1'b1; bus.wr_addr = 9'd20; bus.wr_data = 3'd7;
        cyc(1);
        bus.rd_addr = 9'd2; bus.wr_addr = 9'd21; bus.wr_data = 3'd6;
        cyc(1);
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        cyc(1);
        bus.rd_req = 1'b1; bus.rd_addr = 9'd3;
        cyc(1);
        bus.rd_req = 1'b0;
        cyc(1);
        bus.rd_req = 1'b1; bus.rd_addr = 9'd4;
        cyc(1);
        bus.rd_req = 1'b0;
        cyc(3);
        check("prio_pulses", we_count - base, 2);
        check("prio_ram20", int'(ram[20]), 7);
        check("prio_ram21", int'(ram[21]), 6);

        // Async reset while a drain pulse is in flight.
        bus.video_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = 9'(30 + i); bus.wr_data = 3'(i + 1);
            cyc(1);
        end
        bus.wr_req = 1'b0; bus.video_on = 1'b0;
        check("pre_rst_pending", int'(bus.pending), 3);
        @(posedge clk);
        #1;
        check("inflight_we", int'(bus.ram_we), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_we", int'(bus.ram_we), 0);
        check("arst_pending", int'(bus.pending), 0);
        base = we_count;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        check("post_rst_pulses", we_count - base, 0);
        check("post_rst_ram30", int'(ram[30]), 6);
        check("post_rst_ram31", int'(ram[31]), 7);
        check("post_rst_ram32", int'(ram[32]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
